// File: rtl/lfsr_stream_ctrl.sv
// Job sequencer for one LFSR/comparator stochastic bit-stream generator:
// loads threshold and seed, runs the LFSR for len cycles, counts qualified ones.
module lfsr_stream_ctrl #(
  parameter int unsigned WL      = 8,
  parameter int unsigned LW      = 10,
  parameter int unsigned CMP_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [WL-1:0] req_thresh,
  input  logic [WL-1:0] req_seed,
  input  logic [LW-1:0] req_len,
  input  logic          abort,
  output logic          thr_wen,
  output logic [WL-1:0] thr_d,
  output logic          lfsr_load,
  output logic [WL-1:0] lfsr_seed,
  output logic          lfsr_en,
  input  logic          cmp_bit,
  output logic          bit_valid,
  output logic          bit_out,
  output logic          res_valid,
  output logic [LW-1:0] res_count,
  input  logic          res_ready,
  output logic          busy
);

  localparam int unsigned PW = (CMP_LAT > 0) ? CMP_LAT : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [WL-1:0] thresh_q, thresh_d;
  logic [WL-1:0] seed_q, seed_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] remain_q, remain_d;
  logic [LW-1:0] count_q, count_d;
  logic [PW-1:0] vpipe_q, vpipe_d;
  logic          thr_wen_q, thr_wen_d;
  logic          lfsr_load_q, lfsr_load_d;
  logic          lfsr_en_q, lfsr_en_d;
  logic          res_valid_q, res_valid_d;
  logic [LW-1:0] res_count_q, res_count_d;
  logic          busy_q, busy_d;
  logic          flush;
  logic [PW-1:0] pipe_rest;

  // Valid pipe tracks which cmp_bit cycles belong to enabled LFSR steps.
  assign bit_valid = (CMP_LAT == 0) ? lfsr_en_q : vpipe_q[PW-1];
  assign bit_out   = bit_valid & cmp_bit;
  assign req_ready = (state_q == S_IDLE);

  assign thr_wen   = thr_wen_q;
  assign thr_d     = thresh_q;
  assign lfsr_load = lfsr_load_q;
  assign lfsr_seed = seed_q;
  assign lfsr_en   = lfsr_en_q;
  assign res_valid = res_valid_q;
  assign res_count = res_count_q;
  assign busy      = busy_q;

  always_comb begin
    state_d   = state_q;
    thresh_d  = thresh_q;
    seed_d    = seed_q;
    len_d     = len_q;
    remain_d  = remain_q;
    count_d   = count_q;
    flush     = 1'b0;
    pipe_rest = vpipe_q << 1;

    if (bit_valid && cmp_bit && (count_q != {LW{1'b1}})) begin
      count_d = count_q + LW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          thresh_d = req_thresh;
          seed_d   = (req_seed == '0) ? WL'(1) : req_seed;
          len_d    = req_len;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (len_q != '0) begin
          remain_d = len_q;
          state_d  = S_RUN;
        end else begin
          state_d = S_DONE;
        end
      end
      S_RUN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (remain_q == LW'(1)) begin
          state_d = (CMP_LAT == 0) ? S_DONE : S_DRAIN;
        end else begin
          remain_d = remain_q - LW'(1);
        end
      end
      S_DRAIN: begin
        if (abort) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (pipe_rest == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          count_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      count_d = '0;
    end
    vpipe_d = flush ? '0 : ((vpipe_q << 1) | PW'(lfsr_en_q));

    // Strobes are registered decodes of the next state.
    thr_wen_d   = (state_d == S_LOAD);
    lfsr_load_d = (state_d == S_LOAD);
    lfsr_en_d   = (state_d == S_RUN);
    res_valid_d = (state_d == S_DONE);
    res_count_d = (state_d == S_DONE) ? count_d : '0;
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      thresh_q    <= '0;
      seed_q      <= '0;
      len_q       <= '0;
      remain_q    <= '0;
      count_q     <= '0;
      vpipe_q     <= '0;
      thr_wen_q   <= 1'b0;
      lfsr_load_q <= 1'b0;
      lfsr_en_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_count_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      thresh_q    <= thresh_d;
      seed_q      <= seed_d;
      len_q       <= len_d;
      remain_q    <= remain_d;
      count_q     <= count_d;
      vpipe_q     <= vpipe_d;
      thr_wen_q   <= thr_wen_d;
      lfsr_load_q <= lfsr_load_d;
      lfsr_en_q   <= lfsr_en_d;
      res_valid_q <= res_valid_d;
      res_count_q <= res_count_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_lfsr_stream_ctrl.sv
// Bench for lfsr_stream_ctrl: three builds (CMP_LAT 1, 0, 4), each with an
// LFSR/comparator datapath model, checked against an abstract job model.
`timescale 1ns/1ps
module tb_lfsr_stream_ctrl;

  localparam int NI = 3;
  localparam int LAT [NI] = '{1, 0, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [NI], req_valid [NI], req_ready [NI], abort [NI];
  logic       thr_wen [NI], lfsr_load [NI], lfsr_en [NI], cmp_bit [NI];
  logic       bit_valid [NI], bit_out [NI], res_valid [NI], res_ready [NI], busy [NI];
  logic [7:0] req_thresh [NI], req_seed [NI], thr_d [NI], lfsr_seed [NI];
  logic [9:0] req_len [NI], res_count [NI];

  int n_cmp = 0;
  int n_bad = 0;
  bit force1 = 1'b0;

  logic [7:0] lf [NI]    = '{default: '0};
  logic [7:0] thr_r [NI] = '{default: '0};
  logic [4:0] hist [NI]  = '{default: '0};
  logic       raw [NI];

  lfsr_stream_ctrl #(.WL(8), .LW(10), .CMP_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_thresh(req_thresh[0]), .req_seed(req_seed[0]), .req_len(req_len[0]), .abort(abort[0]),
    .thr_wen(thr_wen[0]), .thr_d(thr_d[0]), .lfsr_load(lfsr_load[0]), .lfsr_seed(lfsr_seed[0]),
    .lfsr_en(lfsr_en[0]), .cmp_bit(cmp_bit[0]), .bit_valid(bit_valid[0]), .bit_out(bit_out[0]),
    .res_valid(res_valid[0]), .res_count(res_count[0]), .res_ready(res_ready[0]), .busy(busy[0]));

  lfsr_stream_ctrl #(.WL(8), .LW(10), .CMP_LAT(0)) u_lat0 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_thresh(req_thresh[1]), .req_seed(req_seed[1]), .req_len(req_len[1]), .abort(abort[1]),
    .thr_wen(thr_wen[1]), .thr_d(thr_d[1]), .lfsr_load(lfsr_load[1]), .lfsr_seed(lfsr_seed[1]),
    .lfsr_en(lfsr_en[1]), .cmp_bit(cmp_bit[1]), .bit_valid(bit_valid[1]), .bit_out(bit_out[1]),
    .res_valid(res_valid[1]), .res_count(res_count[1]), .res_ready(res_ready[1]), .busy(busy[1]));

  lfsr_stream_ctrl #(.WL(8), .LW(10), .CMP_LAT(4)) u_lat4 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_thresh(req_thresh[2]), .req_seed(req_seed[2]), .req_len(req_len[2]), .abort(abort[2]),
    .thr_wen(thr_wen[2]), .thr_d(thr_d[2]), .lfsr_load(lfsr_load[2]), .lfsr_seed(lfsr_seed[2]),
    .lfsr_en(lfsr_en[2]), .cmp_bit(cmp_bit[2]), .bit_valid(bit_valid[2]), .bit_out(bit_out[2]),
    .res_valid(res_valid[2]), .res_count(res_count[2]), .res_ready(res_ready[2]), .busy(busy[2]));

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Datapath model: LFSR + threshold register + comparator delayed by CMP_LAT.
  always_comb for (int k = 0; k < NI; k++) raw[k] = (lf[k] < thr_r[k]);
  assign cmp_bit[0] = force1 | hist[0][0];
  assign cmp_bit[1] = force1 | raw[1];
  assign cmp_bit[2] = force1 | hist[2][3];

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (lfsr_load[k]) lf[k] <= lfsr_seed[k];
      else if (lfsr_en[k]) lf[k] <= lfsr_next(lf[k]);
      if (thr_wen[k]) thr_r[k] <= thr_d[k];
      hist[k] <= {hist[k][3:0], raw[k]};
    end
  end

  task automatic run_job(input int k, input logic [7:0] thr, input logic [7:0] seed,
                         input logic [9:0] len, input int abort_rel, input int hold,
                         input bit ab_accept);
    logic [7:0] v, sd;
    bit exp_bits[$];
    int ones, rel, en_cnt, bv_cnt, bit_err, first_en, res_rel, quiet_err, exp_en;
    sd = (seed == 8'd0) ? 8'd1 : seed;
    v = sd;
    ones = 0;
    for (int i = 0; i < int'(len); i++) begin
      exp_bits.push_back(force1 || (v < thr));
      if (force1 || (v < thr)) ones++;
      v = lfsr_next(v);
    end
    req_valid[k] = 1'b1; req_thresh[k] = thr; req_seed[k] = seed; req_len[k] = len;
    abort[k] = ab_accept; res_ready[k] = 1'b0;
    n_cmp++;
    if (req_ready[k] !== 1'b1) begin
      n_bad++; $display("FAIL accept_ready k=%0d got %b want 1", k, req_ready[k]);
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0; req_thresh[k] = 8'($urandom); req_seed[k] = 8'($urandom);
    req_len[k] = 10'($urandom); abort[k] = (abort_rel == 1);
    n_cmp++;
    if ({thr_wen[k], lfsr_load[k], lfsr_en[k], busy[k], thr_d[k], lfsr_seed[k]} !== {4'b1101, thr, sd}) begin
      n_bad++; $display("FAIL load_cycle k=%0d got wen/ld/en/busy=%b%b%b%b thr=%0h seed=%0h want 1101 thr=%0h seed=%0h",
        k, thr_wen[k], lfsr_load[k], lfsr_en[k], busy[k], thr_d[k], lfsr_seed[k], thr, sd);
    end
    rel = 1; en_cnt = 0; bv_cnt = 0; bit_err = 0; first_en = -1; res_rel = -1;
    while (res_rel < 0 && rel < 1200 && (abort_rel < 0 || rel <= abort_rel)) begin
      @(posedge clk); #1; rel++;
      abort[k] = (rel == abort_rel);
      if (lfsr_en[k]) begin
        if (first_en < 0) first_en = rel;
        en_cnt++;
      end
      if (bit_valid[k]) begin
        if (bv_cnt < exp_bits.size() && bit_out[k] !== exp_bits[bv_cnt]) bit_err++;
        bv_cnt++;
      end
      if (res_valid[k]) res_rel = rel;
    end
    abort[k] = 1'b0;
    if (abort_rel > 0) begin
      exp_en = (abort_rel - 1 < int'(len)) ? abort_rel - 1 : int'(len);
      n_cmp++;
      if ({req_ready[k], busy[k], lfsr_en[k], bit_valid[k], res_valid[k]} !== 5'b10000) begin
        n_bad++; $display("FAIL abort_next k=%0d got rdy/busy/en/bv/rv=%b%b%b%b%b want 10000",
          k, req_ready[k], busy[k], lfsr_en[k], bit_valid[k], res_valid[k]);
      end
      n_cmp++;
      if (en_cnt !== exp_en) begin
        n_bad++; $display("FAIL abort_en_count k=%0d got %0d want %0d", k, en_cnt, exp_en);
      end
      quiet_err = 0;
      for (int i = 0; i < 12 + LAT[k]; i++) begin
        @(posedge clk); #1;
        if (res_valid[k] || lfsr_en[k] || bit_valid[k] || busy[k]) quiet_err++;
      end
      n_cmp++;
      if (quiet_err !== 0) begin
        n_bad++; $display("FAIL abort_quiet k=%0d got %0d active cycles want 0", k, quiet_err);
      end
      return;
    end
    n_cmp++;
    if (first_en !== ((len == 0) ? -1 : 2)) begin
      n_bad++; $display("FAIL first_en k=%0d got %0d want %0d", k, first_en, (len == 0) ? -1 : 2);
    end
    n_cmp++;
    if (en_cnt !== int'(len)) begin
      n_bad++; $display("FAIL en_count k=%0d got %0d want %0d", k, en_cnt, len);
    end
    n_cmp++;
    if (bv_cnt !== int'(len)) begin
      n_bad++; $display("FAIL bit_valid_count k=%0d got %0d want %0d", k, bv_cnt, len);
    end
    n_cmp++;
    if (bit_err !== 0) begin
      n_bad++; $display("FAIL bit_stream k=%0d got %0d wrong bits want 0", k, bit_err);
    end
    n_cmp++;
    if (res_rel !== ((len == 0) ? 2 : 2 + int'(len) + LAT[k])) begin
      n_bad++; $display("FAIL res_latency k=%0d got %0d want %0d", k, res_rel,
        (len == 0) ? 2 : 2 + int'(len) + LAT[k]);
    end
    n_cmp++;
    if (res_count[k] !== 10'(ones)) begin
      n_bad++; $display("FAIL res_count k=%0d got %0d want %0d", k, res_count[k], ones);
    end
    if (hold > 0) begin
      req_valid[k] = 1'b1; req_thresh[k] = 8'h3C; req_seed[k] = 8'h11; req_len[k] = 10'd0;
      for (int i = 0; i < hold; i++) begin
        abort[k] = (i == 3);
        @(posedge clk); #1;
        n_cmp++;
        if ({res_valid[k], req_ready[k], res_count[k]} !== {2'b10, 10'(ones)}) begin
          n_bad++; $display("FAIL done_hold k=%0d cyc=%0d got rv/rdy=%b%b cnt=%0d want 10 cnt=%0d",
            k, i, res_valid[k], req_ready[k], res_count[k], ones);
        end
      end
      abort[k] = 1'b0;
    end
    res_ready[k] = 1'b1;
    @(posedge clk); #1;
    res_ready[k] = 1'b0;
    n_cmp++;
    if ({res_valid[k], busy[k], req_ready[k]} !== 3'b001) begin
      n_bad++; $display("FAIL after_handshake k=%0d got rv/busy/rdy=%b%b%b want 001",
        k, res_valid[k], busy[k], req_ready[k]);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      n_cmp++;
      if ({thr_wen[k], thr_d[k], lfsr_seed[k]} !== {1'b1, 8'h3C, 8'h11}) begin
        n_bad++; $display("FAIL next_job_load k=%0d got wen=%b thr=%0h seed=%0h want 1 3c 11",
          k, thr_wen[k], thr_d[k], lfsr_seed[k]);
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({res_valid[k], res_count[k]} !== {1'b1, 10'd0}) begin
        n_bad++; $display("FAIL next_job_done k=%0d got rv=%b cnt=%0d want 1 0", k, res_valid[k], res_count[k]);
      end
      res_ready[k] = 1'b1;
      @(posedge clk); #1;
      res_ready[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if ({thr_wen[k], lfsr_load[k], lfsr_en[k], bit_valid[k], bit_out[k], res_valid[k], busy[k],
           res_count[k], thr_d[k], lfsr_seed[k]} !== 33'd0) begin
        n_bad++; $display("FAIL reset_outputs k=%0d got nonzero en=%b rv=%b busy=%b cnt=%0d want all 0",
          k, lfsr_en[k], res_valid[k], busy[k], res_count[k]);
      end
    end
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if ({req_ready[k], busy[k]} !== 2'b10) begin
        n_bad++; $display("FAIL post_reset_ready k=%0d got rdy/busy=%b%b want 10", k, req_ready[k], busy[k]);
      end
    end
  endtask

  task automatic test_basic();
    run_job(0, 8'h80, 8'h5A, 10'd16, -1, 0, 1'b0);
  endtask

  task automatic test_len_zero();
    run_job(0, 8'h40, 8'h33, 10'd0, -1, 0, 1'b0);
  endtask

  task automatic test_seed_zero_full();
    force1 = 1'b1;
    run_job(0, 8'hFF, 8'h00, 10'd1023, -1, 0, 1'b0);
    force1 = 1'b0;
  endtask

  task automatic test_abort();
    run_job(0, 8'h9D, 8'h21, 10'd100, 6, 0, 1'b0);
    run_job(0, 8'h9D, 8'hC7, 10'd4, -1, 0, 1'b0);
    run_job(0, 8'h70, 8'h05, 10'd3, 1, 0, 1'b0);
  endtask

  task automatic test_done_hold();
    run_job(0, 8'($urandom), 8'($urandom), 10'd12, -1, 10, 1'b0);
  endtask

  task automatic test_random();
    logic [9:0] len;
    int ab, mx;
    for (int i = 0; i < 8; i++) begin
      len = 10'($urandom_range(0, 40));
      mx = (len == 0) ? 1 : int'(len) + 1 + LAT[0];
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, mx)) : -1;
      run_job(0, 8'($urandom), ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom), len, ab, 0,
              1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_cmp_lat();
    for (int k = 1; k < NI; k++) begin
      run_job(k, 8'h80, 8'h5A, 10'd8, -1, 0, 1'b0);
      run_job(k, 8'($urandom), 8'($urandom), 10'($urandom_range(1, 20)), -1, 0, 1'b0);
      run_job(k, 8'($urandom), 8'($urandom), 10'd8, 5, 0, 1'b0);
    end
  endtask

  task automatic test_reset_drain();
    req_valid[2] = 1'b1; req_thresh[2] = 8'hA0; req_seed[2] = 8'h77; req_len[2] = 10'd8;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if ({lfsr_en[2], busy[2], res_valid[2]} !== 3'b010) begin
      n_bad++; $display("FAIL in_drain got en/busy/rv=%b%b%b want 010", lfsr_en[2], busy[2], res_valid[2]);
    end
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    n_cmp++;
    if ({thr_wen[2], lfsr_load[2], lfsr_en[2], bit_valid[2], bit_out[2], res_valid[2], busy[2],
         res_count[2], thr_d[2], lfsr_seed[2], req_ready[2]} !== 34'd1) begin
      n_bad++; $display("FAIL drain_reset got bv=%b rv=%b busy=%b thr=%0h seed=%0h rdy=%b want all 0 rdy=1",
        bit_valid[2], res_valid[2], busy[2], thr_d[2], lfsr_seed[2], req_ready[2]);
    end
    run_job(2, 8'($urandom), 8'($urandom), 10'd8, -1, 0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_thresh[k] = '0; req_seed[k] = '0;
      req_len[k] = '0; abort[k] = 1'b0; res_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_len_zero();
    test_seed_zero_full();
    test_abort();
    test_done_hold();
    test_random();
    test_cmp_lat();
    test_reset_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_stream_ctrl.md
Name: lfsr_stream_ctrl

Overview:
- Sequencer for one LFSR/comparator stochastic bit-stream generator: threshold register, seedable LFSR and comparator with a pipelined output.
- Accepts a job (threshold, seed, stream length) over valid/ready.
- Loads the threshold register and the LFSR seed, then runs the LFSR for the requested number of cycles.
- Qualifies and streams the comparator bits, counts the ones, and returns the count over valid/ready. Sits between the neuron/layer scheduler and the bit-stream datapath.

Parameters:
- WL, 8, width of threshold, seed and LFSR value.
- LW, 10, width of stream length and ones count.
- CMP_LAT, 1, cycles from an lfsr_en=1 cycle to its cmp_bit; legal range 0..4.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  job request valid.
- req_ready  out  1  ready for a job; high only in IDLE.
- req_thresh  in  WL  comparator threshold.
- req_seed  in  WL  LFSR seed; 0 is remapped to 1.
- req_len  in  LW  stream length in cycles; 0 is legal.
- abort  in  1  cancel the current job.
- thr_wen  out  1  write enable for the threshold register.
- thr_d  out  WL  threshold register data.
- lfsr_load  out  1  LFSR seed load strobe.
- lfsr_seed  out  WL  seed value.
- lfsr_en  out  1  LFSR advance enable.
- cmp_bit  in  1  comparator output (LFSR < threshold), CMP_LAT-delayed.
- bit_valid  out  1  qualified stream bit strobe.
- bit_out  out  1  qualified stream bit.
- res_valid  out  1  ones count valid.
- res_count  out  LW  number of qualified 1 bits.
- res_ready  in  1  result consumer ready.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, LOAD, RUN, DRAIN, DONE. Outputs are registered unless stated otherwise.
- Reset (rst=1 at posedge):
  - state=IDLE; all strobes, bit_out, res_valid, res_count=0.
  - thr_d, lfsr_seed=0; valid-pipe cleared.
  - req_ready=1 from the first cycle after reset deasserts.
  - rst has priority over every other input.
- IDLE:
  - req_ready=1 (combinational from state).
  - On req_valid&req_ready: capture thresh, seed (0 becomes 1) and len; go to LOAD.
- LOAD, exactly 1 cycle:
  - thr_wen=1, lfsr_load=1; thr_d and lfsr_seed hold the captured values.
  - Next state is RUN if len!=0, else DONE with count=0.
- RUN:
  - lfsr_en=1 for exactly len consecutive cycles; a down-counter reloads from len.
  - Each lfsr_en=1 cycle pushes a 1 into a CMP_LAT-deep valid pipe; other cycles push 0.
  - After the last enable cycle, go to DRAIN. If CMP_LAT=0, skip DRAIN and go to DONE.
- Bit qualification:
  - bit_valid = valid-pipe output; bit_out = cmp_bit in the same cycle (combinational pass-through, no added latency).
  - count increments on bit_valid&cmp_bit. It saturates at 2^LW-1, which is unreachable for len <= 2^LW-1.
- DRAIN: stay until the valid pipe is empty (CMP_LAT cycles), then go to DONE.
- DONE:
  - res_valid=1 and res_count=count, both held stable until res_ready=1.
  - On handshake: go to IDLE and clear count.
  - The earliest next job acceptance is the cycle after the handshake; there is no back-to-back overlap.
- Latency: request accept at cycle t → LOAD at t+1 → RUN at t+2..t+1+len → res_valid at t+2+len+CMP_LAT.
- abort:
  - Sampled in LOAD, RUN and DRAIN: go to IDLE next cycle, flush the valid pipe, clear count, no result.
  - lfsr_en and bit_valid are 0 from the next cycle.
  - Ignored in IDLE and DONE: a pending result is not discarded.
  - abort together with req_valid in IDLE: the request is accepted.
- req_valid while busy: not accepted (req_ready=0); the requester must hold its payload.
- Reset mid-job: same as abort, plus full register reset.
- Input changes on req_* after acceptance have no effect.

Test Plan:
1. WL=8, LW=10, CMP_LAT=1; thresh=0x80, seed=0x5A, len=16, cmp_bit driven by a model → LOAD strobes in cycle t+1; lfsr_en high for exactly 16 cycles; 16 bit_valid pulses; res_count equals model ones count; res_valid at t+19.
2. len=0 → one LOAD cycle, no lfsr_en, no bit_valid; res_valid=1 with res_count=0 at t+2.
3. seed=0 and thresh=0xFF with cmp_bit held 1 and len=1023 → lfsr_seed=0x01 during LOAD; res_count=1023; busy drops after the handshake.
4. abort on the 5th RUN cycle with len=100 → IDLE next cycle; no res_valid; lfsr_en and bit_valid 0 thereafter. A new job with len=4 then yields res_count equal to that job's ones only.
5. res_ready held low for 10 cycles in DONE, with req_valid=1 and abort pulsed → res_valid and res_count stable, req_ready=0; the result completes after res_ready=1, and the new request is accepted 1 cycle after the handshake.
6. CMP_LAT=0 and CMP_LAT=4 builds, len=8 → DRAIN lasts 0 and 4 cycles respectively; exactly 8 bit_valid pulses each; rst asserted mid-DRAIN returns all outputs to reset values next cycle.
